// File: rtl/sdr_demux_pkg.sv
// Shared types and header-field constants for the FTDI receive packet demultiplexer.
package sdr_demux_pkg;

    typedef enum logic [0:0] {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } demux_state_e;

    localparam int FT_DATA_WIDTH_DEF = 32;
    localparam int DEST_BITS_DEF     = 2;
    localparam int LEN_WIDTH_DEF     = 16;
    localparam int DROP_CNT_W        = 16;

    // The destination field sits at the top of the header word.
    function automatic int dest_msb(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/sdr_demux_watchdog.sv
// Mid-packet idle watchdog: pulses timeout_o after TIMEOUT_CYCLES idle cycles while run_i is high.
module sdr_demux_watchdog
#(
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic clk_i,
    input  logic reset_n,
    input  logic run_i,
    input  logic kick_i,
    output logic timeout_o
);

    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    // Down-counter holds the idle cycles left before the terminal count.
    logic [CNT_W-1:0] idle_q, idle_d;

    assign timeout_o = run_i && !kick_i && (idle_q == '0);

    always_comb begin
        idle_d = idle_q - CNT_W'(1);
        if (!run_i || kick_i || timeout_o) begin
            idle_d = RELOAD;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= RELOAD;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/ft_rx_demux.sv
// Header/payload packet demultiplexer from the FTDI stream to NUM_DEST sinks.
// Optional mid-packet watchdog enabled by defining SDR_DEMUX_TIMEOUT_EN.
//
// state   | meaning
// HDR     | next accepted word is a header (dest + length)
// PAYLOAD | accepted words are forwarded to cur_dest until the count runs out
module ft_rx_demux
    import sdr_demux_pkg::*;
#(
    parameter int FT_DATA_WIDTH    = FT_DATA_WIDTH_DEF,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16,
    parameter int NUM_DEST         = 4,
    parameter int DEST_BITS        = DEST_BITS_DEF,
    parameter int LEN_WIDTH        = LEN_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES   = 1024
)(
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic [FT_DATA_WIDTH-1:0] data_i,
    input  logic                     we_i,
    output logic                     full_o,
    output logic                     enough_o,
    output logic [FT_DATA_WIDTH-1:0] dst_data_o,
    output logic [IQ_PAIR_WIDTH-1:0] iq_data_o,
    output logic [NUM_DEST-1:0]      dst_we_o,
    input  logic [NUM_DEST-1:0]      dst_full_i,
    input  logic [NUM_DEST-1:0]      dst_enough_i,
    output logic                     busy_o,
    output logic [DEST_BITS-1:0]     cur_dest_o,
    output logic                     err_o,
    input  logic                     err_clr_i,
    output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

    localparam int                   IQ_HALF    = IQ_PAIR_WIDTH / 2;
    localparam int                   DEST_MSB   = dest_msb(FT_DATA_WIDTH);
    localparam logic [DEST_BITS:0]   NUM_DEST_W = (DEST_BITS + 1)'(NUM_DEST);

    if (NUM_DEST < 2 || NUM_DEST > (2 ** DEST_BITS) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ft_rx_demux: NUM_DEST or TIMEOUT_CYCLES out of range");
    end

    demux_state_e              state_q, state_d;
    logic [DEST_BITS-1:0]      cur_dest_q, cur_dest_d;
    logic [LEN_WIDTH-1:0]      rem_q, rem_d;
    logic [FT_DATA_WIDTH-1:0]  dst_data_q, dst_data_d;
    logic [IQ_PAIR_WIDTH-1:0]  iq_q, iq_d;
    logic [NUM_DEST-1:0]       dst_we_q, dst_we_d;
    logic                      err_q, err_d;
    logic [DROP_CNT_W-1:0]     drop_q, drop_d;

    logic [DEST_BITS-1:0]      hdr_dest;
    logic [LEN_WIDTH-1:0]      hdr_len;
    logic                      hdr_dest_ok, dest_ok;
    logic                      full_sel, enough_sel;
    logic                      err_set;
    logic                      timeout;

    assign hdr_dest    = data_i[DEST_MSB -: DEST_BITS];
    assign hdr_len     = data_i[LEN_WIDTH-1:0];
    assign hdr_dest_ok = {1'b0, hdr_dest} < NUM_DEST_W;
    assign dest_ok     = {1'b0, cur_dest_q} < NUM_DEST_W;

    // An illegal destination matches no index, so both selects fall to 0.
    always_comb begin
        full_sel   = 1'b0;
        enough_sel = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (cur_dest_q == DEST_BITS'(i)) begin
                full_sel   = dst_full_i[i];
                enough_sel = dst_enough_i[i];
            end
        end
    end

`ifdef SDR_DEMUX_TIMEOUT_EN
    sdr_demux_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .run_i     (state_q == PAYLOAD),
        .kick_i    (we_i),
        .timeout_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_dest_d = cur_dest_q;
        rem_d      = rem_q;
        dst_data_d = dst_data_q;
        iq_d       = iq_q;
        dst_we_d   = '0;
        drop_d     = drop_q;
        err_set    = 1'b0;
        case (state_q)
            HDR: begin
                if (we_i) begin
                    cur_dest_d = hdr_dest;
                    rem_d      = hdr_len;
                    err_set    = !hdr_dest_ok;
                    if (hdr_len != '0) begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (timeout) begin
                    state_d = HDR;
                    err_set = 1'b1;
                end else if (we_i) begin
                    // Count every word, dropped or not, so framing survives overflow.
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = HDR;
                    end
                    if (!dest_ok) begin
                        err_set = 1'b1;
                    end else if (full_sel) begin
                        err_set = 1'b1;
                        if (drop_q != '1) begin
                            drop_d = drop_q + DROP_CNT_W'(1);
                        end
                    end else begin
                        dst_data_d = data_i;
                        iq_d       = {data_i[QSTART_BIT_INDEX+IQ_HALF-1:QSTART_BIT_INDEX],
                                      data_i[IQ_HALF-1:0]};
                        dst_we_d   = NUM_DEST'(1) << cur_dest_q;
                    end
                end
            end
            default: state_d = HDR;
        endcase
        err_d = err_set || (err_q && !err_clr_i);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HDR;
            cur_dest_q <= '0;
            rem_q      <= '0;
            dst_data_q <= '0;
            iq_q       <= '0;
            dst_we_q   <= '0;
            err_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_dest_q <= cur_dest_d;
            rem_q      <= rem_d;
            dst_data_q <= dst_data_d;
            iq_q       <= iq_d;
            dst_we_q   <= dst_we_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    assign full_o     = (state_q == PAYLOAD) && full_sel;
    assign enough_o   = enough_sel;
    assign busy_o     = (state_q == PAYLOAD);
    assign cur_dest_o = cur_dest_q;
    assign dst_data_o = dst_data_q;
    assign iq_data_o  = iq_q;
    assign dst_we_o   = dst_we_q;
    assign err_o      = err_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_ft_rx_demux.sv
// Directed self-checking bench for ft_rx_demux (NUM_DEST = 3, so destination 3 is illegal).
module tb_ft_rx_demux;

    logic        clk_i = 1'b0;
    logic        reset_n;
    logic [31:0] data_i;
    logic        we_i;
    logic        full_o, enough_o;
    logic [31:0] dst_data_o;
    logic [23:0] iq_data_o;
    logic [2:0]  dst_we_o;
    logic [2:0]  dst_full_i, dst_enough_i;
    logic        busy_o;
    logic [1:0]  cur_dest_o;
    logic        err_o, err_clr_i;
    logic [15:0] drop_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    ft_rx_demux #(.NUM_DEST(3)) dut (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .data_i       (data_i),
        .we_i         (we_i),
        .full_o       (full_o),
        .enough_o     (enough_o),
        .dst_data_o   (dst_data_o),
        .iq_data_o    (iq_data_o),
        .dst_we_o     (dst_we_o),
        .dst_full_i   (dst_full_i),
        .dst_enough_i (dst_enough_i),
        .busy_o       (busy_o),
        .cur_dest_o   (cur_dest_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [31:0] d, input logic we);
        data_i = d;
        we_i   = we;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; drive(32'h0, 1'b0);
        dst_full_i = 3'b000; dst_enough_i = 3'b001; err_clr_i = 1'b0;
        repeat (3) tick();
        n_checks++; if (full_o !== 1'b0) $display("FAIL reset_full: got %b want 0", full_o); else n_pass++;
        n_checks++; if (enough_o !== 1'b1) $display("FAIL reset_enough: got %b want 1", enough_o); else n_pass++;
        n_checks++; if (dst_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", dst_data_o); else n_pass++;
        n_checks++; if (iq_data_o !== 24'h0) $display("FAIL reset_iq: got %h want 0", iq_data_o); else n_pass++;
        n_checks++; if (dst_we_o !== 3'b000) $display("FAIL reset_we: got %b want 000", dst_we_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (cur_dest_o !== 2'd0) $display("FAIL reset_dest: got %0d want 0", cur_dest_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (drop_cnt_o !== 16'h0) $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); else n_pass++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_normal_and_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
        drive(32'h4000_0003, 1'b1);
        tick();
        n_checks++; if (busy_o !== 1'b1) $display("FAIL norm_busy_hdr: got %b want 1", busy_o); else n_pass++;
        n_checks++; if (cur_dest_o !== 2'd1) $display("FAIL norm_dest: got %0d want 1", cur_dest_o); else n_pass++;
        n_checks++; if (dst_we_o !== 3'b000) $display("FAIL norm_hdr_not_fwd: got %b want 000", dst_we_o); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(words[i], 1'b1);
            tick();
            n_checks++; if (dst_we_o !== 3'b010) $display("FAIL norm_we[%0d]: got %b want 010", i, dst_we_o); else n_pass++;
            n_checks++; if (dst_data_o !== words[i]) $display("FAIL norm_data[%0d]: got %h want %h", i, dst_data_o, words[i]); else n_pass++;
            n_checks++; if (busy_o !== (i < 2)) $display("FAIL norm_busy[%0d]: got %b want %b", i, busy_o, i < 2); else n_pass++;
        end
        // next header arrives right after the last payload word, no bubble
        drive(32'h8000_0001, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b000) $display("FAIL b2b_hdr_we: got %b want 000", dst_we_o); else n_pass++;
        n_checks++; if (cur_dest_o !== 2'd2) $display("FAIL b2b_dest: got %0d want 2", cur_dest_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy_o); else n_pass++;
        drive(32'h0000_0055, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b100) $display("FAIL b2b_we: got %b want 100", dst_we_o); else n_pass++;
        n_checks++; if (dst_data_o !== 32'h55) $display("FAIL b2b_data: got %h want 55", dst_data_o); else n_pass++;
        drive(32'h0, 1'b0);
        tick();
        n_checks++; if (dst_we_o !== 3'b000) $display("FAIL b2b_we_single: got %b want 000", dst_we_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL b2b_idle_busy: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_empty();
        drive(32'h8000_0000, 1'b1);
        tick();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL empty_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (dst_we_o !== 3'b000) $display("FAIL empty_we: got %b want 000", dst_we_o); else n_pass++;
        drive(32'h4000_0001, 1'b1);
        tick();
        n_checks++; if (cur_dest_o !== 2'd1) $display("FAIL empty_next_dest: got %0d want 1", cur_dest_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b1) $display("FAIL empty_next_busy: got %b want 1", busy_o); else n_pass++;
        drive(32'h0000_0077, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b010) $display("FAIL empty_next_we: got %b want 010", dst_we_o); else n_pass++;
        drive(32'h0, 1'b0);
        tick();
    endtask

    task automatic test_iq_packing();
        drive(32'h0000_0001, 1'b1);
        tick();
        drive(32'h0123_4567, 1'b1);
        tick();
        n_checks++; if (iq_data_o !== 24'h123567) $display("FAIL iq_pack: got %h want 123567", iq_data_o); else n_pass++;
        n_checks++; if (dst_data_o !== 32'h0123_4567) $display("FAIL iq_data: got %h want 01234567", dst_data_o); else n_pass++;
        n_checks++; if (dst_we_o !== 3'b001) $display("FAIL iq_we: got %b want 001", dst_we_o); else n_pass++;
        drive(32'h0, 1'b0);
        tick();
    endtask

    task automatic test_overflow();
        dst_full_i = 3'b100;
        #1;
        n_checks++; if (full_o !== 1'b0) $display("FAIL ovf_full_in_hdr: got %b want 0", full_o); else n_pass++;
        dst_full_i = 3'b000; dst_enough_i = 3'b100;
        drive(32'h8000_0002, 1'b1);
        tick();
        n_checks++; if (enough_o !== 1'b1) $display("FAIL ovf_enough: got %b want 1", enough_o); else n_pass++;
        drive(32'h0000_0011, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b100) $display("FAIL ovf_first_we: got %b want 100", dst_we_o); else n_pass++;
        dst_full_i = 3'b100;
        drive(32'h0000_0022, 1'b1);
        #1;
        n_checks++; if (full_o !== 1'b1) $display("FAIL ovf_full: got %b want 1", full_o); else n_pass++;
        tick();
        n_checks++; if (dst_we_o !== 3'b000) $display("FAIL ovf_drop_we: got %b want 000", dst_we_o); else n_pass++;
        n_checks++; if (dst_data_o !== 32'h11) $display("FAIL ovf_data_held: got %h want 11", dst_data_o); else n_pass++;
        n_checks++; if (drop_cnt_o !== 16'd1) $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt_o); else n_pass++;
        n_checks++; if (err_o !== 1'b1) $display("FAIL ovf_err: got %b want 1", err_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL ovf_framing: got %b want 0", busy_o); else n_pass++;
        dst_full_i = 3'b000;
        drive(32'h0, 1'b0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        n_checks++; if (err_o !== 1'b0) $display("FAIL ovf_err_clr: got %b want 0", err_o); else n_pass++;
        n_checks++; if (drop_cnt_o !== 16'd1) $display("FAIL ovf_drop_kept: got %0d want 1", drop_cnt_o); else n_pass++;
    endtask

    task automatic test_illegal_dest();
        dst_full_i = 3'b111;
        drive(32'hC000_0002, 1'b1);
        tick();
        n_checks++; if (cur_dest_o !== 2'd3) $display("FAIL ill_dest: got %0d want 3", cur_dest_o); else n_pass++;
        n_checks++; if (full_o !== 1'b0) $display("FAIL ill_full: got %b want 0", full_o); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(32'h1 + 32'(i), 1'b1);
            tick();
            n_checks++; if (dst_we_o !== 3'b000) $display("FAIL ill_we[%0d]: got %b want 000", i, dst_we_o); else n_pass++;
        end
        n_checks++; if (err_o !== 1'b1) $display("FAIL ill_err: got %b want 1", err_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL ill_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (drop_cnt_o !== 16'd1) $display("FAIL ill_no_drop: got %0d want 1", drop_cnt_o); else n_pass++;
        dst_full_i = 3'b000;
        drive(32'h0000_0001, 1'b1);
        tick();
        n_checks++; if (cur_dest_o !== 2'd0) $display("FAIL ill_next_dest: got %0d want 0", cur_dest_o); else n_pass++;
        drive(32'h0000_0009, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b001) $display("FAIL ill_next_we: got %b want 001", dst_we_o); else n_pass++;
        drive(32'h0, 1'b0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

`ifdef SDR_DEMUX_TIMEOUT_EN
    task automatic test_timeout();
        drive(32'h0000_0005, 1'b1);
        tick();
        repeat (2) begin
            drive(32'h0000_0033, 1'b1);
            tick();
        end
        drive(32'h0, 1'b0);
        repeat (1023) tick();
        n_checks++; if (busy_o !== 1'b1) $display("FAIL to_busy_before: got %b want 1", busy_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL to_err_before: got %b want 0", err_o); else n_pass++;
        tick();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL to_busy_after: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (err_o !== 1'b1) $display("FAIL to_err_after: got %b want 1", err_o); else n_pass++;
        drive(32'h4000_0001, 1'b1);
        tick();
        n_checks++; if (cur_dest_o !== 2'd1) $display("FAIL to_next_dest: got %0d want 1", cur_dest_o); else n_pass++;
        drive(32'h0000_0044, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b010) $display("FAIL to_next_we: got %b want 010", dst_we_o); else n_pass++;
        drive(32'h0, 1'b0);
        tick();
    endtask
`else
    task automatic test_no_watchdog();
        drive(32'h0000_0002, 1'b1);
        tick();
        drive(32'h0000_0033, 1'b1);
        tick();
        drive(32'h0, 1'b0);
        repeat (1100) tick();
        n_checks++; if (busy_o !== 1'b1) $display("FAIL nowd_busy: got %b want 1", busy_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL nowd_err: got %b want 0", err_o); else n_pass++;
        drive(32'h0000_0034, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b001) $display("FAIL nowd_we: got %b want 001", dst_we_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL nowd_done: got %b want 0", busy_o); else n_pass++;
        drive(32'h0, 1'b0);
        tick();
    endtask
`endif

    task automatic test_reset_mid_packet();
        dst_enough_i = 3'b001;
        drive(32'h4000_0003, 1'b1);
        tick();
        drive(32'h0000_00AA, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b010) $display("FAIL rst_mid_pre_we: got %b want 010", dst_we_o); else n_pass++;
        drive(32'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        n_checks++; if (dst_we_o !== 3'b000) $display("FAIL rst_mid_we: got %b want 000", dst_we_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (cur_dest_o !== 2'd0) $display("FAIL rst_mid_dest: got %0d want 0", cur_dest_o); else n_pass++;
        n_checks++; if (dst_data_o !== 32'h0) $display("FAIL rst_mid_data: got %h want 0", dst_data_o); else n_pass++;
        n_checks++; if (iq_data_o !== 24'h0) $display("FAIL rst_mid_iq: got %h want 0", iq_data_o); else n_pass++;
        n_checks++; if (drop_cnt_o !== 16'h0) $display("FAIL rst_mid_drop: got %0d want 0", drop_cnt_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (enough_o !== 1'b1) $display("FAIL rst_mid_enough: got %b want 1", enough_o); else n_pass++;
        tick();
        reset_n = 1'b1;
        drive(32'h8000_0001, 1'b1);
        tick();
        n_checks++; if (cur_dest_o !== 2'd2) $display("FAIL rst_mid_hdr_dest: got %0d want 2", cur_dest_o); else n_pass++;
        drive(32'h0000_00BB, 1'b1);
        tick();
        n_checks++; if (dst_we_o !== 3'b100) $display("FAIL rst_mid_next_we: got %b want 100", dst_we_o); else n_pass++;
        drive(32'h0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_normal_and_back_to_back();
        test_empty();
        test_iq_packing();
        test_overflow();
        test_illegal_dest();
`ifdef SDR_DEMUX_TIMEOUT_EN
        test_timeout();
`else
        test_no_watchdog();
`endif
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
